// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use bubbles, data-memory
// wait-state freeze, taken-branch IF/ID flush, sticky memory timeout and stall counter.
module hazard_stall_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_RegisterRt,
   input  logic [4:0]       IF_ID_RegisterRs,
   input  logic [4:0]       IF_ID_RegisterRt,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             PCWrite_o,
   output logic             IF_ID_Write_o,
   output logic             IF_ID_Flush_o,
   output logic             ID_EX_Bubble_o,
   output logic             Pipe_Freeze_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam int WC_W = $clog2(TIMEOUT + 1);
   localparam logic [WC_W-1:0]  WC_ZERO = WC_W'(0);
   localparam logic [WC_W-1:0]  WC_ONE  = WC_W'(1);
   localparam logic [WC_W-1:0]  WC_MAX  = {WC_W{1'b1}};
   localparam logic [WC_W-1:0]  WC_THR  = WC_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t           state_q, state_d;
   logic             pend_flush_q, pend_flush_d;
   logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic loaduse_s;
   logic pc_write_s, if_id_write_s, flush_s, bubble_s, freeze_s;

   // $zero is never a real load destination, so it cannot create a hazard
   assign loaduse_s = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                      ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                       (ID_EX_RegisterRt == IF_ID_RegisterRt));

   // State register with asynchronous active-low reset
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= ST_RUN;
         pend_flush_q <= 1'b0;
         wait_cnt_q   <= WC_ZERO;
         timeout_q    <= 1'b0;
         stall_cnt_q  <= {CNT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         pend_flush_q <= pend_flush_d;
         wait_cnt_q   <= wait_cnt_d;
         timeout_q    <= timeout_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   // Next-state logic: wait tracking, deferred branch flush, timeout and stall counting
   always_comb begin
      state_d      = state_q;
      pend_flush_d = pend_flush_q;
      wait_cnt_d   = wait_cnt_q;
      timeout_d    = timeout_q;
      stall_cnt_d  = stall_cnt_q;
      case (state_q)
         ST_RUN: begin
            if (mem_req_i && !mem_ack_i) begin
               state_d      = ST_WAIT;
               pend_flush_d = branch_taken_i;
               wait_cnt_d   = WC_ONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_WAIT: begin
            if (!mem_ack_i) begin
               pend_flush_d = pend_flush_q | branch_taken_i;
               if (wait_cnt_q != WC_MAX) begin
                  wait_cnt_d = wait_cnt_q + WC_ONE;
               end else begin
                  wait_cnt_d = wait_cnt_q;
               end
               if (wait_cnt_d >= WC_THR) begin
                  timeout_d = 1'b1;
               end else begin
                  timeout_d = timeout_q;
               end
            end else begin
               state_d      = ST_RUN;
               pend_flush_d = 1'b0;
               wait_cnt_d   = WC_ZERO;
            end
         end
         default: begin
            state_d      = ST_RUN;
            pend_flush_d = 1'b0;
            wait_cnt_d   = WC_ZERO;
         end
      endcase
      if (!pc_write_s && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Output decode; every enable is held low while reset is asserted
   always_comb begin
      pc_write_s    = 1'b1;
      if_id_write_s = 1'b1;
      flush_s       = 1'b0;
      bubble_s      = 1'b0;
      freeze_s      = 1'b0;
      if (!rst_i) begin
         pc_write_s    = 1'b0;
         if_id_write_s = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (mem_req_i && !mem_ack_i) begin
                  freeze_s      = 1'b1;
                  pc_write_s    = 1'b0;
                  if_id_write_s = 1'b0;
               end else if (loaduse_s) begin
                  pc_write_s    = 1'b0;
                  if_id_write_s = 1'b0;
                  bubble_s      = 1'b1;
               end else begin
                  flush_s = branch_taken_i;
               end
            end
            ST_WAIT: begin
               // Release cycle skips load-use detection; only the deferred flush applies
               if (!mem_ack_i) begin
                  freeze_s      = 1'b1;
                  pc_write_s    = 1'b0;
                  if_id_write_s = 1'b0;
               end else begin
                  flush_s = pend_flush_q;
               end
            end
            default: begin
               pc_write_s    = 1'b0;
               if_id_write_s = 1'b0;
            end
         endcase
      end
   end

   assign PCWrite_o      = pc_write_s;
   assign IF_ID_Write_o  = if_id_write_s;
   assign IF_ID_Flush_o  = flush_s;
   assign ID_EX_Bubble_o = bubble_s;
   assign Pipe_Freeze_o  = freeze_s;
   assign timeout_o      = timeout_q;
   assign stall_cnt_o    = stall_cnt_q;

endmodule
